// File: rtl/aes_spi_pkg.sv
// Shared types for the AES SPI front end: controller states and the frame length rule.
package aes_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        SEND
    } state_e;

    // A frame is one direction bit, the key, then the 128-bit message.
    function automatic int flen(input int k);
        return k + 129;
    endfunction

endpackage

// File: rtl/aes_spi_slave_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC-1:0] chain_q;
    logic            prev_q;

    // NOTE: every flop here uses <= so all stages sample the old value on the same edge;
    // blocking assignments would collapse the chain into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC-2:0], async_i};
            prev_q  <= chain_q[SYNC-1];
        end
    end

    assign sync_o = chain_q[SYNC-1];
    assign rise_o = chain_q[SYNC-1] & ~prev_q;
    assign fall_o = ~chain_q[SYNC-1] & prev_q;

endmodule

// File: rtl/aes_spi_slave.sv
// SPI slave in front of the AES core: collects {dir, key, message} from the Pi, starts the
// core, captures its result and shifts it back out MSB first.
module aes_spi_slave
    import aes_spi_pkg::*;
#(
    parameter int K    = 128,
    parameter int SYNC = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           done,
    output logic           frame_err,
    output logic           core_ce,
    output logic           core_dir,
    output logic [K-1:0]   core_key,
    output logic [127:0]   core_message,
    input  logic           core_done,
    input  logic [127:0]   core_translated
);

    localparam int FLEN = flen(K);
    localparam int BW   = $clog2(FLEN + 2);
    localparam logic [BW-1:0] BIT_FULL = BW'(FLEN);
    localparam logic [BW-1:0] BIT_SAT  = BW'(FLEN + 1);

    logic sck_r, sck_f, load_r, load_f, sdi_s, cdone_s;
    logic sck_s_unused, load_s_unused, sdi_rise_unused, sdi_fall_unused;
    logic cdone_rise_unused, cdone_fall_unused;

    sync_edge #(.SYNC(SYNC)) u_sck (
        .clk(clk), .reset(reset), .async_i(sck),
        .sync_o(sck_s_unused), .rise_o(sck_r), .fall_o(sck_f)
    );
    sync_edge #(.SYNC(SYNC)) u_load (
        .clk(clk), .reset(reset), .async_i(load),
        .sync_o(load_s_unused), .rise_o(load_r), .fall_o(load_f)
    );
    sync_edge #(.SYNC(SYNC)) u_sdi (
        .clk(clk), .reset(reset), .async_i(sdi),
        .sync_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );
    sync_edge #(.SYNC(SYNC)) u_cdone (
        .clk(clk), .reset(reset), .async_i(core_done),
        .sync_o(cdone_s), .rise_o(cdone_rise_unused), .fall_o(cdone_fall_unused)
    );

    state_e            state_q, state_d;
    logic [FLEN-1:0]   frame_q, frame_d;
    logic [127:0]      out_q, out_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [7:0]        ocnt_q, ocnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              armed_q, armed_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            out_q    <= '0;
            bitcnt_q <= '0;
            ocnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            out_q    <= out_d;
            bitcnt_q <= bitcnt_d;
            ocnt_q   <= ocnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            armed_q  <= armed_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        out_d    = out_q;
        bitcnt_d = bitcnt_q;
        ocnt_d   = ocnt_q;
        done_d   = done_q;
        err_d    = 1'b0;
        armed_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_r) begin
                    state_d  = LOAD;
                    bitcnt_d = '0;
                    done_d   = 1'b0;
                end
            end
            LOAD: begin
                // Load edges take priority; a coincident sck edge is dropped.
                if (load_f) begin
                    if (bitcnt_q == BIT_FULL) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (sck_r && !load_r) begin
                    frame_d = {frame_q[FLEN-2:0], sdi_s};
                    if (bitcnt_q != BIT_SAT) begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end
            RUN: begin
                if (load_r) begin
                    state_d  = LOAD;
                    bitcnt_d = '0;
                    done_d   = 1'b0;
                end else begin
                    // A done level left over from the previous operation must drop first.
                    armed_d = armed_q | ~cdone_s;
                    if (armed_q && cdone_s) begin
                        out_d   = core_translated;
                        ocnt_d  = '0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (load_r) begin
                    state_d  = LOAD;
                    bitcnt_d = '0;
                    done_d   = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (sck_f && !load_f) begin
                        out_d  = {out_q[126:0], 1'b0};
                        ocnt_d = ocnt_q + 8'd1;
                        if (ocnt_q == 8'd127) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_ce = (state_q == LOAD);
        sdo     = (state_q == SEND) ? out_q[127] : 1'b0;
    end

    assign done         = done_q;
    assign frame_err    = err_q;
    assign core_dir     = frame_q[FLEN-1];
    assign core_key     = frame_q[FLEN-2 -: K];
    assign core_message = frame_q[127:0];

endmodule
